uart_rx_fsm: RTL

- Control state machine of the UART receiver. Tracks one frame: start bit, IN_DATA_WIDTH data bits, optional parity bit, stop bit.
- Drives the edge/bit counter enable and consumes its edge_cnt and bit_cnt.
- Generates the enables for the data sampler, deserializer, parity checker, start checker and stop checker.
- Qualifies the received byte with a single-cycle data_valid pulse.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_fsm.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
package uart_rx_pkg;

  // Frame-tracking states, 3-bit binary encoding.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    ERR_CHK = 3'd5
  } rx_state_e;

  // The sampler registers its majority vote this many edges past mid-bit,
  // so the deserializer shift strobe is placed there.
  localparam logic [5:0] DESER_OFFSET = 6'd2;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: walks start, data, optional parity and stop bits,
// enables the per-bit checkers and qualifies the received byte.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             RX_IN,
  input  logic                             PAR_EN,
  input  logic [5:0]                       Prescale,
  input  logic [5:0]                       edge_cnt,
  input  logic [$clog2(IN_DATA_WIDTH):0]   bit_cnt,
  input  logic                             strt_glitch,
  input  logic                             par_err,
  input  logic                             stp_err,
  output logic                             edge_bit_en,
  output logic                             dat_samp_en,
  output logic                             deser_en,
  output logic                             par_chk_en,
  output logic                             strt_chk_en,
  output logic                             stp_chk_en,
  output logic                             data_valid
);

  localparam int BCW = $clog2(IN_DATA_WIDTH) + 1;
  localparam logic [BCW-1:0] LAST_DATA_BIT = BCW'(IN_DATA_WIDTH);

  rx_state_e state_q, state_d;
  logic      par_en_q, par_en_d;

  logic [5:0] edge_last;
  logic [5:0] edge_stop_end;
  logic [5:0] edge_deser;
  logic       bit_end;

  assign edge_last     = Prescale - 6'd1;
  // Stop ends one edge early so the counter clears while still inside the stop bit.
  assign edge_stop_end = Prescale - 6'd2;
  assign edge_deser    = (Prescale >> 1) + DESER_OFFSET;
  assign bit_end       = (edge_cnt == edge_last);

  // State and latched parity-enable registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
    end
  end

  // Next-state logic; PAR_EN is captured only when a new frame begins.
  always_comb begin
    state_d  = state_q;
    par_en_d = par_en_q;
    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d  = START;
          par_en_d = PAR_EN;
        end
      end
      START: begin
        if (bit_end) state_d = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == LAST_DATA_BIT)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (edge_cnt == edge_stop_end) state_d = ERR_CHK;
      end
      ERR_CHK: begin
        if (!RX_IN) begin
          state_d  = START;
          par_en_d = PAR_EN;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state, edge count and checker flags.
  always_comb begin
    edge_bit_en = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    strt_chk_en = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state_q)
      START: begin
        edge_bit_en = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = 1'b1;
      end
      DATA: begin
        edge_bit_en = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = (edge_cnt == edge_deser);
      end
      PARITY: begin
        edge_bit_en = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = 1'b1;
      end
      STOP: begin
        edge_bit_en = 1'b1;
        dat_samp_en = 1'b1;
        stp_chk_en  = 1'b1;
      end
      ERR_CHK: begin
        data_valid = ~stp_err & (~par_en_q | ~par_err);
      end
      default: ;
    endcase
  end

endmodule
